// File: rtl/hex_glyph_pkg.sv
// hex_glyph_pkg: shared 3x5 hex glyph table, geometry and decoder state.
// Row k of a glyph sits at bits [14-3k:12-3k]; bit 2 of a row is leftmost.
package hex_glyph_pkg;

  localparam int GLYPH_ROWS = 5;
  localparam int GLYPH_COLS = 3;
  localparam int GLYPH_BITS = GLYPH_ROWS * GLYPH_COLS;

  localparam logic [14:0] GLYPH_0 = 15'b111_101_101_101_111;
  localparam logic [14:0] GLYPH_1 = 15'b100_100_100_100_100;
  localparam logic [14:0] GLYPH_2 = 15'b111_001_111_100_111;
  localparam logic [14:0] GLYPH_3 = 15'b111_001_111_001_111;
  localparam logic [14:0] GLYPH_4 = 15'b101_101_111_001_001;
  localparam logic [14:0] GLYPH_5 = 15'b111_100_111_001_111;
  localparam logic [14:0] GLYPH_6 = 15'b111_100_111_101_111;
  localparam logic [14:0] GLYPH_7 = 15'b111_001_001_001_001;
  localparam logic [14:0] GLYPH_8 = 15'b111_101_111_101_111;
  localparam logic [14:0] GLYPH_9 = 15'b111_101_111_001_111;
  localparam logic [14:0] GLYPH_A = 15'b111_101_111_101_101;
  localparam logic [14:0] GLYPH_B = 15'b110_101_110_101_110;
  localparam logic [14:0] GLYPH_C = 15'b111_100_100_100_111;
  localparam logic [14:0] GLYPH_D = 15'b110_101_101_101_110;
  localparam logic [14:0] GLYPH_E = 15'b111_100_111_100_111;
  localparam logic [14:0] GLYPH_F = 15'b111_100_111_100_100;

  typedef enum logic [1:0] {
    GET_L,
    GET_R,
    MATCH,
    OUT
  } state_t;

  function automatic logic [14:0] glyph_of(input logic [3:0] n);
    logic [14:0] g;
    case (n)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

  // Horizontal mirror: reverse the three columns of every row.
  function automatic logic [14:0] mirror(input logic [14:0] g);
    logic [14:0] m;
    for (int k = 0; k < GLYPH_ROWS; k++) begin
      m[3*k+2] = g[3*k];
      m[3*k+1] = g[3*k+1];
      m[3*k]   = g[3*k+2];
    end
    return m;
  endfunction

endpackage

// File: rtl/hex_glyph_decoder_match.sv
// glyph_match: combinational lookup of one 15-bit glyph in the hex table.
// HEX_GLYPH_MIRROR_TOLERANT_EN adds a mirrored retry after a direct miss.
module glyph_match
  import hex_glyph_pkg::*;
(
  input  logic [14:0] glyph,
  output logic [3:0]  nibble,
  output logic        hit
);

  logic [3:0] d_nib;
  logic       d_hit;

  // Direct lookup; scanning downward lets the lowest index win.
  always_comb begin
    d_nib = 4'h0;
    d_hit = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (glyph == glyph_of(4'(i))) begin
        d_nib = 4'(i);
        d_hit = 1'b1;
      end
    end
  end

`ifdef HEX_GLYPH_MIRROR_TOLERANT_EN
  logic [14:0] m_glyph;
  logic [3:0]  m_nib;
  logic        m_hit;

  assign m_glyph = mirror(glyph);

  // Mirrored lookup, only consulted when the direct lookup misses.
  always_comb begin
    m_nib = 4'h0;
    m_hit = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (m_glyph == glyph_of(4'(i))) begin
        m_nib = 4'(i);
        m_hit = 1'b1;
      end
    end
  end

  assign nibble = d_hit ? d_nib : m_nib;
  assign hit    = d_hit | m_hit;
`else
  assign nibble = d_nib;
  assign hit    = d_hit;
`endif

endmodule

// File: rtl/hex_glyph_decoder.sv
// hex_glyph_decoder: rebuilds a byte from two 3x5 glyphs sent row by row.
// Optional HEX_GLYPH_MIRROR_TOLERANT_EN accepts mirrored glyphs.
module hex_glyph_decoder
  import hex_glyph_pkg::*;
#(
  parameter logic [3:0] ERR_NIBBLE = 4'h0,
  parameter bit         LEFT_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] row_in,
  input  logic       row_sof,
  input  logic       row_valid,
  output logic       row_ready,
  output logic [7:0] byte_out,
  output logic [1:0] byte_err,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy
);

  state_t      state;
  logic [2:0]  row_cnt;
  logic [14:0] shift;
  logic [14:0] glyph_l;
  logic [14:0] glyph_r;
  logic [3:0]  nib_h;
  logic [3:0]  nib_l;
  logic        err_h;
  logic        err_l;

  logic        accept;
  logic [14:0] full;
  logic [14:0] glyph_hi;
  logic [14:0] glyph_lo;
  logic [3:0]  hi_nib;
  logic [3:0]  lo_nib;
  logic        hi_hit;
  logic        lo_hit;

  assign accept   = row_valid && row_ready;
  assign full     = {shift[11:0], row_in};
  assign glyph_hi = LEFT_FIRST ? glyph_l : glyph_r;
  assign glyph_lo = LEFT_FIRST ? glyph_r : glyph_l;
  assign busy     = (state != GET_L) || (row_cnt != 3'd0);

  glyph_match u_hi (
    .glyph  (glyph_hi),
    .nibble (hi_nib),
    .hit    (hi_hit)
  );

  glyph_match u_lo (
    .glyph  (glyph_lo),
    .nibble (lo_nib),
    .hit    (lo_hit)
  );

  // Frame FSM: gather L and R rows, match, then hold the byte until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= GET_L;
      row_cnt    <= 3'd0;
      shift      <= 15'd0;
      glyph_l    <= 15'd0;
      glyph_r    <= 15'd0;
      nib_h      <= 4'h0;
      nib_l      <= 4'h0;
      err_h      <= 1'b0;
      err_l      <= 1'b0;
      row_ready  <= 1'b1;
      byte_out   <= 8'h00;
      byte_err   <= 2'b00;
      byte_valid <= 1'b0;
    end else begin
      case (state)
        GET_L, GET_R: begin
          if (accept) begin
            shift <= full;
            if (row_sof) begin
              state   <= GET_L;
              row_cnt <= 3'd1;
            end else if (row_cnt == 3'd4) begin
              row_cnt <= 3'd0;
              if (state == GET_L) begin
                glyph_l <= full;
                state   <= GET_R;
              end else begin
                glyph_r   <= full;
                state     <= MATCH;
                row_ready <= 1'b0;
              end
            end else begin
              row_cnt <= row_cnt + 3'd1;
            end
          end
        end
        MATCH: begin
          nib_h <= hi_hit ? hi_nib : ERR_NIBBLE;
          nib_l <= lo_hit ? lo_nib : ERR_NIBBLE;
          err_h <= !hi_hit;
          err_l <= !lo_hit;
          state <= OUT;
        end
        OUT: begin
          if (!byte_valid) begin
            byte_out   <= {nib_h, nib_l};
            byte_err   <= {err_h, err_l};
            byte_valid <= 1'b1;
          end else if (byte_ready) begin
            byte_valid <= 1'b0;
            row_ready  <= 1'b1;
            row_cnt    <= 3'd0;
            state      <= GET_L;
          end
        end
        default: begin
          state     <= GET_L;
          row_cnt   <= 3'd0;
          row_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_glyph_decoder.sv
// tb_hex_glyph_decoder: random and directed frames against a row-list model.
// Define HEX_GLYPH_MIRROR_TOLERANT_EN for both bench and RTL to test mirroring.
module tb_hex_glyph_decoder;

  localparam logic [3:0] TB_ERR = 4'h0;

  typedef logic [4:0][2:0] rows_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] row_in = 3'd0;
  logic       row_sof = 1'b0;
  logic       row_valid = 1'b0;
  logic       row_ready;
  logic [7:0] byte_out;
  logic [1:0] byte_err;
  logic       byte_valid;
  logic       byte_ready = 1'b1;
  logic       busy;

  hex_glyph_decoder #(
    .ERR_NIBBLE (TB_ERR),
    .LEFT_FIRST (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .row_in     (row_in),
    .row_sof    (row_sof),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .byte_out   (byte_out),
    .byte_err   (byte_err),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  rows_t tbl [16];

  function automatic rows_t mk(int r0, int r1, int r2, int r3, int r4);
    rows_t g;
    g[0] = 3'(r0); g[1] = 3'(r1); g[2] = 3'(r2);
    g[3] = 3'(r3); g[4] = 3'(r4);
    return g;
  endfunction

  function automatic rows_t mir(rows_t g);
    rows_t m;
    for (int k = 0; k < 5; k++) m[k] = {g[k][0], g[k][1], g[k][2]};
    return m;
  endfunction

  // Returns {err, nibble}.
  function automatic logic [4:0] decode(rows_t g);
    for (int i = 0; i < 16; i++)
      if (g == tbl[i]) return {1'b0, 4'(i)};
`ifdef HEX_GLYPH_MIRROR_TOLERANT_EN
    for (int i = 0; i < 16; i++)
      if (mir(g) == tbl[i]) return {1'b0, 4'(i)};
`endif
    return {1'b1, TB_ERR};
  endfunction

  initial begin
    tbl[0]  = mk(7,5,5,5,7); tbl[1]  = mk(4,4,4,4,4);
    tbl[2]  = mk(7,1,7,4,7); tbl[3]  = mk(7,1,7,1,7);
    tbl[4]  = mk(5,5,7,1,1); tbl[5]  = mk(7,4,7,1,7);
    tbl[6]  = mk(7,4,7,5,7); tbl[7]  = mk(7,1,1,1,1);
    tbl[8]  = mk(7,5,7,5,7); tbl[9]  = mk(7,5,7,1,7);
    tbl[10] = mk(7,5,7,5,5); tbl[11] = mk(6,5,6,5,6);
    tbl[12] = mk(7,4,4,4,7); tbl[13] = mk(6,5,5,5,6);
    tbl[14] = mk(7,4,7,4,7); tbl[15] = mk(7,4,7,4,4);
  end

  // Requests from the stimulus process, serviced by the monitor.
  int         lit_id = 0;
  logic [7:0] lit_byte = 8'h00;
  logic [1:0] lit_err = 2'b00;
  int         tmo_cnt = 0;
  bit         end_req = 1'b0;
  int         rdy_mode = 0;

  // Model / monitor state.
  logic [2:0] fr[$];
  logic [9:0] expq[$];
  bit         pending = 1'b0;
  int         done_cyc = 0;
  int         cyc = 0;
  int         xfers = 0;
  int         lit_done = 0;
  int         tmo_seen = 0;
  bit         end_done = 1'b0;
  bit         after_rst = 1'b0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_byte;
  logic [1:0] prev_err;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the frame-level model.
  always @(negedge clk) begin
    rows_t g1, g2;
    logic [4:0] d1, d2;
    logic [9:0] e;
    if (reset) begin
      fr.delete();
      expq.delete();
      pending = 1'b0;
      prev_hold = 1'b0;
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        chk("rst_byte_out", byte_out, 8'h00);
        chk("rst_byte_err", byte_err, 2'b00);
        after_rst = 1'b0;
      end
      chk("row_ready", row_ready, !pending);
      chk("busy", busy, pending || fr.size() != 0);
      chk("byte_valid", byte_valid, pending && (cyc - done_cyc >= 3));
      if (prev_hold) begin
        chk("hold_byte", byte_out, prev_byte);
        chk("hold_err", byte_err, prev_err);
      end
      if (byte_valid && byte_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL xfer_unexpected: got %0h expected none", byte_out);
        end else begin
          e = expq.pop_front();
          chk("byte_out", byte_out, e[7:0]);
          chk("byte_err", byte_err, e[9:8]);
        end
        if (lit_id != lit_done) begin
          chk("lit_byte", byte_out, lit_byte);
          chk("lit_err", byte_err, lit_err);
          lit_done = lit_id;
        end
        pending = 1'b0;
        xfers++;
      end
      prev_hold = byte_valid && !byte_ready;
      prev_byte = byte_out;
      prev_err  = byte_err;
      if (row_valid && row_ready) begin
        if (row_sof) fr.delete();
        fr.push_back(row_in);
        if (fr.size() == 10) begin
          for (int k = 0; k < 5; k++) begin
            g1[k] = fr[k];
            g2[k] = fr[5+k];
          end
          d1 = decode(g1);
          d2 = decode(g2);
          expq.push_back({d1[4], d2[4], d1[3:0], d2[3:0]});
          pending = 1'b1;
          done_cyc = cyc;
          fr.delete();
        end
      end
    end
    if (tmo_cnt != tmo_seen) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d expired waits expected 0", tmo_cnt);
      tmo_seen = tmo_cnt;
    end
    if (end_req && !end_done) begin
      chk("drain", expq.size(), 0);
      end_done = 1'b1;
    end
    cyc++;
  end

  // Consumer ready: 0 = always, 1 = random, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: byte_ready = 1'b1;
      1: byte_ready = 1'($urandom % 2);
      default: byte_ready = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(logic [2:0] r, logic s);
    bit acc;
    int n = 0;
    row_in = r;
    row_sof = s;
    row_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = row_ready && !reset;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) tmo_cnt++;
    row_valid = 1'b0;
    row_sof = 1'b0;
    if ($urandom % 3 == 0) begin
      row_in = 3'($urandom);
      row_sof = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_glyph(rows_t g, logic s);
    for (int k = 0; k < 5; k++) send_row(g[k], (k == 0) ? s : 1'b0);
  endtask

  task automatic set_lit(logic [7:0] b, logic [1:0] e);
    lit_byte = b;
    lit_err = e;
    lit_id++;
  endtask

  task automatic wait_xfer();
    int start = xfers;
    int n = 0;
    while (xfers == start && n < 100) begin
      tick();
      n++;
    end
    if (xfers == start) tmo_cnt++;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!byte_valid && n < 50) begin
      tick();
      n++;
    end
    if (!byte_valid) tmo_cnt++;
  endtask

  task automatic pulse_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic rows_t pick();
    int r = $urandom % 10;
    rows_t g;
    if (r < 7) g = tbl[$urandom % 16];
    else if (r == 7) g = mir(tbl[$urandom % 16]);
    else for (int k = 0; k < 5; k++) g[k] = 3'($urandom);
    return g;
  endfunction

  initial begin
    rows_t g1, g2;
    bit junk;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    set_lit(8'hA0, 2'b00);
    send_glyph(tbl[10], 1'b1);
    send_glyph(tbl[0], 1'b0);
    wait_xfer();

    set_lit({TB_ERR, 4'h1}, 2'b10);
    send_glyph(mk(0,0,0,0,0), 1'b1);
    send_glyph(tbl[1], 1'b0);
    wait_xfer();

    rdy_mode = 2;
    set_lit(8'h57, 2'b00);
    send_glyph(tbl[5], 1'b0);
    send_glyph(tbl[7], 1'b0);
    wait_valid();
    repeat (7) tick();
    rdy_mode = 0;
    wait_xfer();
    repeat (3) tick();

    for (int k = 0; k < 3; k++) send_row(tbl[8][k], k == 0);
    set_lit(8'hFE, 2'b00);
    send_glyph(tbl[15], 1'b1);
    send_glyph(tbl[14], 1'b0);
    wait_xfer();

    send_glyph(tbl[9], 1'b1);
    send_row(tbl[2][0], 1'b0);
    send_row(tbl[2][1], 1'b0);
    pulse_reset();
    set_lit(8'h3C, 2'b00);
    send_glyph(tbl[3], 1'b0);
    send_glyph(tbl[12], 1'b0);
    wait_xfer();

`ifdef HEX_GLYPH_MIRROR_TOLERANT_EN
    set_lit(8'h11, 2'b00);
`else
    set_lit({TB_ERR, TB_ERR}, 2'b11);
`endif
    send_glyph(mk(1,1,1,1,1), 1'b1);
    send_glyph(mk(1,1,1,1,1), 1'b0);
    wait_xfer();

    rdy_mode = 2;
    send_glyph(tbl[6], 1'b1);
    send_glyph(tbl[11], 1'b0);
    wait_valid();
    tick();
    pulse_reset();
    rdy_mode = 1;

    for (int f = 0; f < 40; f++) begin
      junk = ($urandom % 6 == 0);
      if (junk) begin
        int nj = 1 + $urandom % 4;
        for (int j = 0; j < nj; j++) send_row(3'($urandom), 1'($urandom));
      end
      g1 = pick();
      g2 = pick();
      send_glyph(g1, junk ? 1'b1 : 1'($urandom));
      send_glyph(g2, 1'b0);
    end
    rdy_mode = 0;
    repeat (10) tick();
    end_req = 1'b1;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
